// File: rtl/imem_arb.sv
// Shares a single-ported, synchronous-read instruction memory between fetch and a
// debug/loader port. Debug wins by default; a consecutive-grant limit keeps fetch moving.
module imem_arb #(
  parameter int DEPTH      = 256,
  parameter int AW         = $clog2(DEPTH),
  parameter int MAX_CONSEC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [31:0]   d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int          CW  = $clog2(MAX_CONSEC + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Handshake: a request is accepted in the same cycle its gnt is high; until then the
  // requester holds address/data stable. Read responses arrive exactly one cycle later.

  logic [CW-1:0] consec, consec_nx;
  logic          rd_pend, rd_owner, rd_bad;
  logic          f_act, d_act, f_bad, d_bad;
  logic          rd_take, rd_take_bad;

  // Grants are masked during reset so nothing is issued or accepted while rst_n is low.
  assign f_act = f_req & rst_n;
  assign d_act = d_req & rst_n;

  assign f_bad = (|f_addr[31:AW+2]) | (|f_addr[1:0]);
  assign d_bad = (|d_addr[31:AW+2]) | (|d_addr[1:0]);

  always_comb begin
    d_gnt = 1'b0;
    f_gnt = 1'b0;
    if (d_act && (!f_act || (consec < CW'(MAX_CONSEC)))) begin
      d_gnt = 1'b1;
    end else if (f_act) begin
      f_gnt = 1'b1;
    end
  end

  always_comb begin
    consec_nx = consec;
    if (!f_act || f_gnt) begin
      consec_nx = '0;
    end else if (d_gnt && (consec < CW'(MAX_CONSEC))) begin
      consec_nx = consec + CW'(1);
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = f_addr[AW+1:2];
    mem_wdata = d_wdata;
    if (d_gnt) begin
      mem_en   = ~d_bad;
      mem_we   = d_we & ~d_bad;
      mem_addr = d_addr[AW+1:2];
    end else if (f_gnt) begin
      mem_en   = ~f_bad;
    end
  end

  // Every granted read, good or bad, owes its requester exactly one response beat.
  assign rd_take     = f_gnt | (d_gnt & ~d_we);
  assign rd_take_bad = d_gnt ? d_bad : f_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      consec   <= '0;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
      rd_bad   <= 1'b0;
    end else begin
      consec   <= consec_nx;
      rd_pend  <= rd_take;
      rd_owner <= d_gnt;
      rd_bad   <= rd_take_bad;
    end
  end

  assign f_rvalid = rd_pend & ~rd_owner;
  assign d_rvalid = rd_pend & rd_owner;
  assign f_err    = f_rvalid & rd_bad;
  assign f_rdata  = f_rvalid ? (rd_bad ? NOP : mem_rdata) : 32'h0;
  assign d_rdata  = d_rvalid ? (rd_bad ? NOP : mem_rdata) : 32'h0;
  // A rejected debug write is reported in its grant cycle since it never gets a beat.
  assign d_err    = (d_rvalid & rd_bad) | (d_gnt & d_we & d_bad);

endmodule

// File: tb/tb_imem_arb.sv
// Directed and random stimulus for imem_arb, checked against a transaction-level
// model of the arbitration rules, a reference memory image and an expected-response queue.
module tb_imem_arb;
  localparam int DEPTH      = 256;
  localparam int AW         = 8;
  localparam int MAX_CONSEC = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk, rst_n;
  logic          f_req, f_gnt, f_rvalid, f_err;
  logic [31:0]   f_addr, f_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0]   d_addr, d_wdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  imem_arb #(.DEPTH(DEPTH), .AW(AW), .MAX_CONSEC(MAX_CONSEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / reset / memory stub ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem_arr [DEPTH];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
    else if (mem_en)      mem_rdata <= mem_arr[mem_addr];
  end

  // ---------------- reference model + scoreboard ----------------
  logic [31:0] ref_mem [DEPTH];
  logic [33:0] exp_q[$];     // {owner(1=debug), err, data}
  int          m_consec;
  int          compared, mismatched;
  logic        obs_f_gnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_bad(input logic [31:0] a);
    return (a >= 32'(DEPTH * 4)) || (a % 4 != 0);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return $urandom();
    return 32'($urandom_range(0, DEPTH - 1) * 4);
  endfunction

  // One clock cycle: drive just after the edge, sample mid-cycle, advance the model.
  task automatic cycle(input logic fr, input logic [31:0] fa, input logic dr,
                       input logic dw, input logic [31:0] da, input logic [31:0] dwd);
    logic        e_f, e_d, fb, db, e_en, e_we, has, e_fv, e_dv;
    logic [33:0] resp;
    int          idx;
    f_req = fr; f_addr = fa; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    e_d  = dr && (!fr || m_consec < MAX_CONSEC);
    e_f  = fr && !e_d;
    fb   = is_bad(fa);
    db   = is_bad(da);
    e_en = (e_f && !fb) || (e_d && !db);
    e_we = e_d && dw && !db;
    idx  = e_d ? widx(da) : widx(fa);
    has  = (exp_q.size() > 0);
    resp = has ? exp_q.pop_front() : 34'h0;
    e_fv = has && !resp[33];
    e_dv = has && resp[33];
    #4;
    obs_f_gnt = f_gnt;
    chk("f_gnt", f_gnt, e_f);
    chk("d_gnt", d_gnt, e_d);
    chk("mem_en", mem_en, e_en);
    chk("mem_we", mem_we, e_we);
    if (e_en) chk("mem_addr", mem_addr, idx);
    if (e_we) chk("mem_wdata", mem_wdata, dwd);
    chk("f_rvalid", f_rvalid, e_fv);
    chk("f_err", f_err, e_fv && resp[32]);
    chk("f_rdata", f_rdata, e_fv ? resp[31:0] : 32'h0);
    chk("d_rvalid", d_rvalid, e_dv);
    chk("d_err", d_err, (e_dv && resp[32]) || (e_d && dw && db));
    chk("d_rdata", d_rdata, e_dv ? resp[31:0] : 32'h0);
    chk("consec", 32'(dut.consec), m_consec);
    if (e_f) exp_q.push_back({1'b0, fb, fb ? NOP : ref_mem[widx(fa)]});
    if (e_d && !dw) exp_q.push_back({1'b1, db, db ? NOP : ref_mem[widx(da)]});
    if (e_we) ref_mem[widx(da)] = dwd;
    if (!fr || e_f) m_consec = 0;
    else if (e_d && m_consec < MAX_CONSEC) m_consec++;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    compared = 0; mismatched = 0; m_consec = 0;
    rst_n = 1'b0; f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = $urandom();
      mem_arr[i] = ref_mem[i];
    end
    for (int i = 0; i < 3; i++) begin
      ref_mem[i] = 32'hA0 + 32'(i);
      mem_arr[i] = ref_mem[i];
    end
    repeat (2) @(posedge clk);
    #5;
    chk("rst_f_rvalid", f_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_f_rdata", f_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_errs", {f_err, d_err}, 2'b00);
    chk("rst_mem_en", {mem_en, mem_we}, 2'b00);
    chk("rst_consec", 32'(dut.consec), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // fetch-only stream
    cycle(1, 32'h0, 0, 0, 0, 0);
    cycle(1, 32'h4, 0, 0, 0, 0);
    cycle(1, 32'h8, 0, 0, 0, 0);
    idle();

    // debug write then fetch of the same word
    cycle(0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    cycle(1, 32'h10, 0, 0, 0, 0);
    idle();

    // starvation bound: D,D,D,D,F repeating
    for (int i = 0; i < 12; i++) begin
      cycle(1, 32'h4, 1, 0, 32'h8, 0);
      chk("starve_pattern", obs_f_gnt, (i % 5) == 4);
    end
    idle();

    // bad addresses
    cycle(1, 32'h400, 0, 0, 0, 0);
    idle();
    cycle(0, 0, 1, 1, 32'h6, 32'h1234_5678);
    idle();
    cycle(1, 32'h2, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 32'h1000, 0);
    idle();

    // interleaved debug read then fetch read
    cycle(0, 0, 1, 0, 32'h20, 0);
    cycle(1, 32'h24, 0, 0, 0, 0);
    idle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rand_addr(), $urandom());
    end
    idle();

    // reset while a read is in flight and debug holds consec above zero
    cycle(1, 32'h8, 0, 0, 0, 0);
    cycle(1, 32'h8, 1, 0, 32'hC, 0);
    rst_n = 1'b0;
    #1;
    chk("rstmid_f_rvalid", f_rvalid, 1'b0);
    chk("rstmid_d_rvalid", d_rvalid, 1'b0);
    chk("rstmid_mem_en", mem_en, 1'b0);
    chk("rstmid_consec", 32'(dut.consec), 0);
    exp_q.delete();
    m_consec = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 32'h8, 0, 0, 0, 0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/imem_arb.md
# imem_arb

Two-port arbiter and sequencer for the single-ported, word-addressed instruction memory. It shares the memory between the core's fetch stage and a debug/program-loader port. Debug has priority, but a consecutive-grant limit guarantees fetch progress. The memory is synchronous-read (1-cycle latency), and this block tracks which requester owns each returning word.

## Interface
- DEPTH, 256: memory depth in 32-bit words (power of two)
- AW, 8: word-index width, log2(DEPTH)
- MAX_CONSEC, 4: max back-to-back debug grants while fetch is waiting (≥1)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- f_req  in  1  fetch read request
- f_addr  in  32  fetch byte address
- f_gnt  out  1  fetch request accepted this cycle (combinational)
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  32  fetch read data
- f_err  out  1  qualifies f_rvalid: address was out of range or misaligned
- d_req  in  1  debug request
- d_we  in  1  debug write (1) / read (0)
- d_addr  in  32  debug byte address
- d_wdata  in  32  debug write data
- d_gnt  out  1  debug request accepted (combinational)
- d_rvalid  out  1  debug read data valid (reads only)
- d_rdata  out  32  debug read data
- d_err  out  1  qualifies d_rvalid, and pulses with d_gnt on a rejected write
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  word index
- mem_wdata  out  32  write data
- mem_rdata  in  32  memory read data, valid the cycle after mem_en & !mem_we

## Operation
- Word index = addr[AW+1:2]. Out of range = any of addr[31:AW+2] set. Misaligned = addr[1:0] != 0.
- Arbitration, evaluated each cycle:
  - Only one requester active: that requester is granted.
  - Both active and consec < MAX_CONSEC: debug is granted.
  - Both active and consec == MAX_CONSEC: fetch is granted.
- consec counter (width clog2(MAX_CONSEC+1)) updates as follows:
  - Increments on a debug grant while f_req=1.
  - Clears on any fetch grant, or on any cycle with f_req=0.
  - Saturates at MAX_CONSEC.
- A granted request with a valid address drives:
  - mem_en=1
  - mem_we=d_we for debug, 0 for fetch
  - mem_addr = word index
  - mem_wdata=d_wdata
- A granted request with a bad address (out of range or misaligned) does not access memory; mem_en=0.
- A granted read with a bad address still returns a response the next cycle: rvalid=1, err=1, rdata=32'h00000013 (NOP).
- A debug write with a bad address is dropped. d_err pulses in the grant cycle, and d_rvalid is never asserted.
- A debug write with a good address produces no response beat.
- Outstanding-read state is registered and set at each granted read:
  - rd_pend (1 bit)
  - rd_owner (0=fetch, 1=debug)
  - rd_bad (1 bit)
- Response routing comes from that registered state; only the owner's rvalid asserts. rdata is mem_rdata when rd_bad=0, NOP when rd_bad=1.
- When idle, mem_addr and mem_wdata are don't-care; mem_en=0 and mem_we=0 are guaranteed.

## Timing
- Grant is combinational from req, in the same cycle. A requester must hold its address and data stable while req=1 and gnt=0.
- Read latency: rvalid rises exactly 1 cycle after the gnt cycle. Full throughput is one access per cycle, so back-to-back grants pipeline cleanly.
- f_gnt and d_gnt are never both 1. mem_we=1 implies d_gnt=1.
- Reset (async assert):
  - consec=0
  - rd_pend=0
  - f_rvalid=0, d_rvalid=0, f_err=0, d_err=0
  - f_rdata=0, d_rdata=0
  - mem_en=0, mem_we=0
- A read granted in the cycle reset asserts is lost, with no response. After deassert, arbitration restarts with consec=0.
- rdata and err are meaningful only while rvalid=1. Outside those cycles they hold 0.

## Test plan
- Fetch-only stream: f_addr=0,4,8 on consecutive cycles with memory preloaded to 0xA0,0xA1,0xA2.
  - f_gnt=1 every cycle.
  - f_rvalid in cycles 1..3 with f_rdata=0xA0,0xA1,0xA2.
- Debug write then fetch: d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF; next cycle f_addr=0x10.
  - mem_we pulses with mem_addr=4.
  - The following cycle shows f_rvalid=1 with f_rdata=0xDEADBEEF.
- Starvation bound, MAX_CONSEC=4: d_req and f_req held high for 12 cycles.
  - Grant pattern is D,D,D,D,F repeating.
  - consec never exceeds 4, and fetch is granted at cycles 4 and 9.
- Bad addresses:
  - f_addr=0x400 (DEPTH=256) gives mem_en=0, then f_rvalid=1, f_err=1, f_rdata=0x00000013.
  - Debug write to 0x6 gives d_err=1 in the grant cycle, no mem_we, and no d_rvalid.
- Interleaved reads: a debug read of 0x20 granted in cycle n and a fetch read of 0x24 granted in cycle n+1.
  - d_rvalid only in cycle n+1 and f_rvalid only in cycle n+2, each carrying its own word.
- Reset mid-read: assert rst_n=0 in the cycle after a fetch grant.
  - f_rvalid, mem_en and consec go to 0 immediately.
  - After release, a fresh fetch completes with 1-cycle latency.
